// File: rtl/bldc_motor_supervisor.sv
// BLDC channel front-end: soft-start duty ramp, safe reversal, hall validity and sequence checks,
// stall detection and fault retry with lockout between the host duty command and the phase driver.
module bldc_motor_supervisor #(
    parameter int unsigned DUTY_WIDTH       = 10,
    parameter int unsigned RAMP_STEP        = 1,
    parameter int unsigned RAMP_DIV         = 256,
    parameter int unsigned STALL_MIN_DUTY   = 64,
    parameter int unsigned STALL_CYCLES     = 18432,
    parameter int unsigned HALL_BAD_CYCLES  = 8,
    parameter int unsigned RETRY_CYCLES     = 184320,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned HALL_COUNT_WIDTH = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [DUTY_WIDTH-1:0]       duty_cmd,
    input  logic [2:0]                  hall,
    input  logic                        fault_clear,
    output logic                        drv_en,
    output logic                        drv_dir,
    output logic [DUTY_WIDTH-2:0]       drv_duty,
    output logic [HALL_COUNT_WIDTH-1:0] hall_count,
    output logic [1:0]                  state,
    output logic [1:0]                  fault_code,
    output logic                        connected
);

    localparam int unsigned MagW     = DUTY_WIDTH - 1;
    localparam int unsigned MagW1    = DUTY_WIDTH;
    localparam int unsigned PresW    = $clog2(RAMP_DIV);
    localparam int unsigned StallW   = $clog2(STALL_CYCLES + 1);
    localparam int unsigned HealthyW = $clog2(2 * STALL_CYCLES + 1);
    localparam int unsigned BadW     = $clog2(HALL_BAD_CYCLES + 1);
    localparam int unsigned DwellW   = $clog2(RETRY_CYCLES + 1);
    localparam int unsigned RetryW   = $clog2(MAX_RETRIES + 1);

    localparam logic [PresW-1:0]    PresLast    = PresW'(RAMP_DIV - 1);
    localparam logic [StallW-1:0]   StallLast   = StallW'(STALL_CYCLES - 1);
    localparam logic [HealthyW-1:0] HealthyLast = HealthyW'(2 * STALL_CYCLES - 1);
    localparam logic [BadW-1:0]     BadMax      = BadW'(HALL_BAD_CYCLES);
    localparam logic [DwellW-1:0]   DwellLast   = DwellW'(RETRY_CYCLES - 1);
    localparam logic [RetryW-1:0]   RetryMax    = RetryW'(MAX_RETRIES);
    localparam logic [MagW1-1:0]    RampStep    = MagW1'(RAMP_STEP);
    localparam logic [MagW1-1:0]    StallMin    = MagW1'(STALL_MIN_DUTY);

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StFault = 2'd2, StLockout = 2'd3} state_e;

    state_e                      state_q, state_d;
    logic [2:0]                  hall_s1_q, hall_s2_q, last_q, last_d;
    logic [HALL_COUNT_WIDTH-1:0] count_q, count_d;
    logic [PresW-1:0]            pres_q, pres_d;
    logic [StallW-1:0]           stall_q, stall_d;
    logic [HealthyW-1:0]         healthy_q, healthy_d;
    logic [BadW-1:0]             bad_q, bad_d;
    logic [DwellW-1:0]           dwell_q, dwell_d;
    logic [RetryW-1:0]           retry_q, retry_d;
    logic [MagW-1:0]             mag_q, mag_d;
    logic                        dir_q, dir_d;
    logic [1:0]                  code_q, code_d;

    // Forward commutation order 1-3-2-6-4-5-1.
    function automatic logic [2:0] hall_next(input logic [2:0] c);
        case (c)
            3'd1:    hall_next = 3'd3;
            3'd3:    hall_next = 3'd2;
            3'd2:    hall_next = 3'd6;
            3'd6:    hall_next = 3'd4;
            3'd4:    hall_next = 3'd5;
            3'd5:    hall_next = 3'd1;
            default: hall_next = 3'd0;
        endcase
    endfunction

    logic hall_valid, last_valid, hall_moved, step_fwd, step_rev, seq_err;
    logic tick, stall_armed, bad_fault, stall_fault, checks_on, fault_hit, retry_clear;
    logic enter_fault;
    logic [1:0]      fault_sel;
    logic [MagW-1:0] target;
    logic            cmd_dir;
    logic [MagW:0]   ramp_sum;
    logic [MagW-1:0] ramp_next;

    assign hall_valid = (hall_s2_q != 3'b000) && (hall_s2_q != 3'b111);
    assign last_valid = (last_q != 3'b000) && (last_q != 3'b111);
    assign hall_moved = hall_valid && last_valid && (hall_s2_q != last_q);
    assign step_fwd   = hall_moved && (hall_s2_q == hall_next(last_q));
    assign step_rev   = hall_moved && (last_q == hall_next(hall_s2_q));
    assign seq_err    = hall_moved && !step_fwd && !step_rev;

    assign tick        = (pres_q == PresLast);
    assign target      = duty_cmd[MagW-1:0];
    assign cmd_dir     = duty_cmd[DUTY_WIDTH-1];
    // One spare bit so the ramp cannot wrap past the top of the magnitude range.
    assign ramp_sum    = {1'b0, mag_q} + RampStep;
    assign ramp_next   = (ramp_sum > {1'b0, target}) ? target : ramp_sum[MagW-1:0];

    assign stall_armed = (state_q == StRun) && ({1'b0, mag_q} >= StallMin);
    assign bad_fault   = (bad_q >= BadMax);
    assign stall_fault = stall_armed && !step_fwd && !step_rev && (stall_q >= StallLast);
    assign checks_on   = (state_q == StIdle) || (state_q == StRun);
    assign fault_hit   = checks_on && (bad_fault || seq_err || stall_fault);
    assign fault_sel   = bad_fault ? 2'd1 : (seq_err ? 2'd2 : 2'd3);
    assign retry_clear = (state_q == StRun) && !fault_hit && (healthy_q == HealthyLast);

    // Hall tracking, prescaler and supervision counters.
    always_comb begin
        last_d  = hall_valid ? hall_s2_q : last_q;
        count_d = count_q;
        if (step_fwd) begin
            count_d = count_q + HALL_COUNT_WIDTH'(1);
        end else if (step_rev) begin
            count_d = count_q - HALL_COUNT_WIDTH'(1);
        end
        pres_d    = tick ? '0 : pres_q + PresW'(1);
        bad_d     = hall_valid ? '0 : ((bad_q >= BadMax) ? bad_q : bad_q + BadW'(1));
        stall_d   = (!stall_armed || step_fwd || step_rev) ? '0 : stall_q + StallW'(1);
        healthy_d = '0;
        if ((state_q == StRun) && !fault_hit && !retry_clear) begin
            healthy_d = healthy_q + HealthyW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        dir_d       = dir_q;
        code_d      = code_q;
        dwell_d     = '0;
        enter_fault = 1'b0;
        case (state_q)
            StIdle: begin
                mag_d = '0;
                if (fault_hit) begin
                    state_d     = StFault;
                    code_d      = fault_sel;
                    enter_fault = 1'b1;
                end else if (en && hall_valid) begin
                    state_d = StRun;
                    code_d  = 2'd0;
                end
            end
            StRun: begin
                if (fault_hit) begin
                    state_d     = StFault;
                    code_d      = fault_sel;
                    mag_d       = '0;
                    enter_fault = 1'b1;
                end else if (!en) begin
                    state_d = StIdle;
                    mag_d   = '0;
                end else if (cmd_dir != dir_q) begin
                    // Coast to zero before flipping direction.
                    if (mag_q != '0) begin
                        mag_d = '0;
                    end else begin
                        dir_d = cmd_dir;
                    end
                end else if (target <= mag_q) begin
                    mag_d = target;
                end else if (tick) begin
                    mag_d = ramp_next;
                end
            end
            StFault: begin
                mag_d   = '0;
                dwell_d = dwell_q + DwellW'(1);
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    state_d = (retry_q >= RetryMax) ? StLockout : StIdle;
                end
            end
            StLockout: begin
                mag_d = '0;
                if (fault_clear) begin
                    state_d = StIdle;
                    code_d  = 2'd0;
                end
            end
            default: state_d = StIdle;
        endcase

        retry_d = (fault_clear || retry_clear) ? '0 : retry_q;
        if (enter_fault && (retry_d < RetryMax)) begin
            retry_d = retry_d + RetryW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hall_s1_q <= 3'b000;
            hall_s2_q <= 3'b000;
            last_q    <= 3'b000;
            count_q   <= '0;
            pres_q    <= '0;
            stall_q   <= '0;
            healthy_q <= '0;
            bad_q     <= '0;
            dwell_q   <= '0;
            retry_q   <= '0;
            mag_q     <= '0;
            dir_q     <= 1'b0;
            code_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            hall_s1_q <= hall;
            hall_s2_q <= hall_s1_q;
            last_q    <= last_d;
            count_q   <= count_d;
            pres_q    <= pres_d;
            stall_q   <= stall_d;
            healthy_q <= healthy_d;
            bad_q     <= bad_d;
            dwell_q   <= dwell_d;
            retry_q   <= retry_d;
            mag_q     <= mag_d;
            dir_q     <= dir_d;
            code_q    <= code_d;
        end
    end

    assign drv_en     = (state_q == StRun);
    assign drv_dir    = dir_q;
    assign drv_duty   = mag_q;
    assign hall_count = count_q;
    assign state      = state_q;
    assign fault_code = code_q;
    assign connected  = hall_valid && (state_q != StLockout);

endmodule

// File: doc/bldc_motor_supervisor.md
Name: bldc_motor_supervisor

Overview:
Parametrised next-generation BLDC channel front-end. It sits between the sign-magnitude duty command from the host register file and the phase driver. It adds soft-start duty ramping, safe direction reversal, hall validity and sequence checking, stall detection, and fault retry with lockout. One instance is used per wheel or dribbler channel; it outputs the applied direction, magnitude and enable to the phase driver, plus a signed hall position count.

Parameters:
DUTY_WIDTH, 10, command width including sign bit (MSB = direction).
RAMP_STEP, 1, magnitude increment per ramp tick.
RAMP_DIV, 256, clk cycles per ramp tick (>=2).
STALL_MIN_DUTY, 64, applied magnitude at or above which the stall check is armed.
STALL_CYCLES, 18432, cycles without a valid hall edge before a stall fault (1 ms at 18.432 MHz).
HALL_BAD_CYCLES, 8, consecutive invalid hall codes before a hall fault.
RETRY_CYCLES, 184320, FAULT dwell before automatic retry.
MAX_RETRIES, 3, automatic retries before LOCKOUT.
HALL_COUNT_WIDTH, 7, width of the signed hall position counter.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
en  in  1  channel enable
duty_cmd  in  DUTY_WIDTH  MSB direction, LSBs magnitude target
hall  in  3  raw hall sensors (asynchronous)
fault_clear  in  1  one-cycle pulse: leave LOCKOUT, zero retry count
drv_en  out  1  phase driver enable
drv_dir  out  1  applied direction
drv_duty  out  DUTY_WIDTH-1  applied magnitude
hall_count  out  HALL_COUNT_WIDTH  signed position, +1 per forward edge, -1 per reverse edge, wraps
state  out  2  0 IDLE, 1 RUN, 2 FAULT, 3 LOCKOUT
fault_code  out  2  0 none, 1 hall invalid, 2 hall sequence, 3 stall
connected  out  1  synced hall code valid and state != LOCKOUT

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; retry count, ramp prescaler, stall and bad counters 0; hall sync registers and last-valid hall code 0.
- Hall path:
  - Two-flop synchroniser; all checks use the 2nd stage (2-cycle latency).
  - Codes 001..110 are valid; 000 and 111 are invalid.
  - Forward sequence: 1-3-2-6-4-5-1. A valid edge is a change to the adjacent code; it updates hall_count the next cycle.
  - A valid-to-valid non-adjacent change is a sequence error.
  - Invalid codes are ignored for counting; last-valid code is kept.
- Bad counter: increments while the synced code is invalid, clears on any valid code. Reaching HALL_BAD_CYCLES gives fault 1.
- Ramp prescaler: free-running 0..RAMP_DIV-1; tick when it is at RAMP_DIV-1.
- Magnitude control in RUN:
  - Target equal to or below applied: drv_duty = target the next cycle.
  - Target above applied: on each tick, drv_duty = min(applied+RAMP_STEP, target), computed without overflow.
  - Direction change with drv_duty != 0: drv_duty goes to 0 the next cycle, drv_dir flips the cycle after, then ramp-up resumes on ticks.
  - Direction change with drv_duty = 0: drv_dir updates the next cycle.
- Stall counter:
  - Counts in RUN while drv_duty >= STALL_MIN_DUTY.
  - Clears on a valid hall edge or when drv_duty drops below STALL_MIN_DUTY.
  - Reaching STALL_CYCLES gives fault 3.
- FSM:
  - IDLE -> RUN when en=1 and synced hall is valid. drv_en=1 only in RUN. drv_duty starts from 0 and follows the ramp.
  - RUN -> IDLE when en=0: drv_en=0 and drv_duty=0 the next cycle; drv_dir holds.
  - RUN -> FAULT on any fault: fault_code latched, drv_en=0, drv_duty=0 the next cycle, retry count +1, dwell timer cleared.
  - Fault priority when simultaneous: hall invalid > sequence > stall.
  - Fault checks (bad counter, sequence error) run in IDLE and RUN. Stall is checked only in RUN.
  - FAULT -> IDLE after RETRY_CYCLES if retry count < MAX_RETRIES; fault_code keeps its value until the next RUN entry, where it clears to 0.
  - FAULT -> LOCKOUT after RETRY_CYCLES if retry count = MAX_RETRIES.
  - en has no effect in FAULT or LOCKOUT.
  - LOCKOUT -> IDLE on fault_clear: fault_code=0, retry count=0. fault_clear in any other state only zeroes the retry count.
  - The retry count also clears after 2*STALL_CYCLES of continuous fault-free RUN.
- Reset mid-operation overrides everything, including LOCKOUT.

Test Plan:
All cases use RAMP_DIV=4, STALL_CYCLES=100, RETRY_CYCLES=50, MAX_RETRIES=2, DUTY_WIDTH=10.
1. Hall held at 001, en=1, duty_cmd=0x00A -> state RUN after 3 cycles; drv_duty steps 0,1,...,10 on one tick every 4 cycles, then holds at 10; drv_en=1.
2. Running forward at 10, duty_cmd=0x205 (reverse, 5) -> drv_duty=0 next cycle, drv_dir=1 the cycle after, then ramps 1..5; hall sequence 1,5,4 gives hall_count -2.
3. Hall 1->3->2->6->4->5->1 with each code held 8 cycles -> hall_count +6, no fault. Then 1->6 -> fault_code 2, state FAULT, drv_en=0.
4. Duty at 64 with hall frozen -> fault 3 exactly 100 cycles after the last edge. Repeat twice through retries -> state LOCKOUT, connected=0; fault_clear -> IDLE, fault_code 0.
5. Hall 111 for 7 cycles, then valid -> no fault. 111 for 8 cycles -> fault 1. Invalid and illegal jump in the same cycle -> fault_code 1.
6. rst_n=0 during FAULT dwell and during ramp-up -> all outputs 0 and state IDLE next cycle; counters restart from 0.
